// File: rtl/pipelined_tree_multiplier_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined tree multiplier.
package mult_pkg;

  localparam int LATENCY = 3;

  typedef logic [5:0] lvl_cnt_t;

  // Rows remaining after one level of 3:2 compression.
  function automatic int rows_after(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  function automatic int rows_at_level(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++) begin
      r = rows_after(r);
    end
    return r;
  endfunction

  function automatic lvl_cnt_t tree_levels(input int n);
    lvl_cnt_t cnt;
    int r;
    cnt = '0;
    r = n;
    for (int i = 0; i < 32; i++) begin
      if (r > 2) begin
        r = rows_after(r);
        cnt = cnt + lvl_cnt_t'(1);
      end
    end
    return cnt;
  endfunction

  // Baugh-Wooley constant for w-bit signed operands: 2^w + 2^(2w-1), modulo 2^(2w).
  function automatic logic [63:0] bw_correction(input int w);
    return (64'd1 << w) | (64'd1 << (2 * w - 1));
  endfunction

endpackage

// File: rtl/pipelined_tree_multiplier_csa_3to2.sv
// Purpose: bit-parallel 3:2 carry-save adder; a + b + c == sum + carry (mod 2^WIDTH).
// Latency: combinational.
// Backpressure: none, pure datapath.
module csa_3to2 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;

endmodule

// File: rtl/pipelined_tree_multiplier.sv
// Purpose: WIDTH x WIDTH signed/unsigned Wallace tree multiplier with sideband tag.
// Latency: 3 cycles (S1 partial products, S2 carry-save tree, S3 final add).
// Backpressure: single global advance; every stage freezes while the output is stalled.
module pipelined_tree_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = 2 * WIDTH;
  localparam int NLEV = int'(tree_levels(WIDTH));
  localparam logic [63:0] BW_CORR = bw_correction(WIDTH);

  typedef struct packed {
    logic                        vld;
    logic [TAG_W-1:0]            tag;
    logic [WIDTH-1:0][WIDTH:0]   rows;
  } s1_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [PW-1:0]    sum;
    logic [PW-1:0]    carry;
  } s2_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [PW-1:0]    p;
  } s3_t;

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;
  logic adv;

  assign adv      = !s3_q.vld || out_ready;
  assign in_ready = adv;

  // Row j holds a & b[j]; in signed mode bits pairing exactly one sign bit are
  // inverted, and the spare top bit of rows 0 and WIDTH-1 carries the correction.
  always_comb begin
    s1_d     = '0;
    s1_d.vld = in_valid;
    s1_d.tag = in_tag;
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = 0; i < WIDTH; i++) begin
        s1_d.rows[j][i] = (in_a[i] & in_b[j]) ^
                          (in_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
      s1_d.rows[j][WIDTH] = in_signed & BW_CORR[j + WIDTH];
    end
  end

  logic [PW-1:0] tree [NLEV+1][WIDTH];

  for (genvar j = 0; j < WIDTH; j++) begin : g_row
    assign tree[0][j] = {{(WIDTH-1){1'b0}}, s1_q.rows[j]} << j;
  end

  for (genvar l = 0; l < NLEV; l++) begin : g_lvl
    localparam int N  = rows_at_level(WIDTH, l);
    localparam int NG = N / 3;
    localparam int NN = rows_after(N);

    for (genvar g = 0; g < NG; g++) begin : g_csa
      csa_3to2 #(
        .WIDTH (PW)
      ) u_csa (
        .a     (tree[l][3*g]),
        .b     (tree[l][3*g+1]),
        .c     (tree[l][3*g+2]),
        .sum   (tree[l+1][2*g]),
        .carry (tree[l+1][2*g+1])
      );
    end

    for (genvar r = 0; r < N % 3; r++) begin : g_pass
      assign tree[l+1][2*NG+r] = tree[l][3*NG+r];
    end

    for (genvar r = NN; r < WIDTH; r++) begin : g_zero
      assign tree[l+1][r] = '0;
    end
  end

  always_comb begin
    s2_d       = '0;
    s2_d.vld   = s1_q.vld;
    s2_d.tag   = s1_q.tag;
    s2_d.sum   = tree[NLEV][0];
    s2_d.carry = tree[NLEV][1];
  end

  always_comb begin
    s3_d     = '0;
    s3_d.vld = s2_q.vld;
    s3_d.tag = s2_q.tag;
    s3_d.p   = s2_q.sum + s2_q.carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q.vld <= 1'b0;
      s2_q.vld <= 1'b0;
      s3_q     <= '0;
    end else if (adv) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign out_valid = s3_q.vld;
  assign out_p     = s3_q.p;
  assign out_tag   = s3_q.tag;

endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Bench for pipelined_tree_multiplier: WIDTH=8 directed/streaming tests plus WIDTH=4/16/32 random sweeps.
module tb_pipelined_tree_multiplier;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        iv8, ir8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [3:0]  t8, ot8;
  logic [15:0] p8;

  pipelined_tree_multiplier #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_signed(s8), .in_tag(t8), .out_valid(ov8), .out_ready(or8), .out_p(p8), .out_tag(ot8)
  );

  logic        sw_iv [3];
  logic        sw_ir [3];
  logic        sw_s  [3];
  logic        sw_ov [3];
  logic        sw_or [3];
  logic [31:0] sw_a  [3];
  logic [31:0] sw_b  [3];
  logic [3:0]  sw_t  [3];
  logic [3:0]  sw_ot [3];
  logic [63:0] sw_p  [3];

  for (genvar k = 0; k < 3; k++) begin : g_sw
    localparam int W = (k == 0) ? 4 : ((k == 1) ? 16 : 32);
    logic [2*W-1:0] p_w;
    pipelined_tree_multiplier #(.WIDTH(W), .TAG_W(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(sw_iv[k]), .in_ready(sw_ir[k]),
      .in_a(sw_a[k][W-1:0]), .in_b(sw_b[k][W-1:0]), .in_signed(sw_s[k]), .in_tag(sw_t[k]),
      .out_valid(sw_ov[k]), .out_ready(sw_or[k]), .out_p(p_w), .out_tag(sw_ot[k])
    );
    assign sw_p[k] = 64'(p_w);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Exact product from plain integer arithmetic, reduced to 2*w bits.
  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic sgn);
    longint sa, sb;
    logic [63:0] m, ua, ub;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    sa = longint'(ua);
    sb = longint'(ub);
    if (sgn && ua[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && ub[w-1]) sb = sb - (longint'(1) << w);
    return 64'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'(m);
      2:       return 32'(64'd1 << (w - 1));
      default: return $urandom & 32'(m);
    endcase
  endfunction

  // WIDTH=8 scoreboard: every cycle out of reset, output checked against the model queue.
  logic [15:0] q8_p [$];
  logic [3:0]  q8_t [$];

  initial forever begin
    @(negedge clk);
    #1;
    if (rst) begin
      q8_p.delete();
      q8_t.delete();
    end else begin
      check("in_ready_rule", 64'(ir8), 64'(!ov8 || or8));
      if (q8_p.size() == 0) begin
        check("no_spurious_out", 64'(ov8), 64'd0);
      end else if (ov8) begin
        check("p_vs_model", 64'(p8), 64'(q8_p[0]));
        check("tag_vs_model", 64'(ot8), 64'(q8_t[0]));
        if (or8) begin
          void'(q8_p.pop_front());
          void'(q8_t.pop_front());
        end
      end
      if (iv8 && ir8) begin
        q8_p.push_back(16'(ref_prod(8, 32'(a8), 32'(b8), s8)));
        q8_t.push_back(t8);
      end
    end
  end

  task automatic single8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [15:0] exp, input string nm);
    @(negedge clk);
    a8 = a; b8 = b; s8 = s; t8 = 4'(t8 + 4'd1); iv8 = 1'b1; or8 = 1'b1;
    #1 check({nm, "_accept"}, 64'(ir8), 64'd1);
    for (int k = 1; k <= LATENCY; k++) begin
      @(negedge clk);
      iv8 = 1'b0;
      #1;
      if (k < LATENCY) begin
        check({nm, "_early"}, 64'(ov8), 64'd0);
      end else begin
        check({nm, "_valid"}, 64'(ov8), 64'd1);
        check(nm, 64'(p8), 64'(exp));
      end
    end
  endtask

  task automatic sweep(input int k, input int w);
    logic [63:0] eq [$];
    logic [3:0]  tq [$];
    int acc, cyc;
    acc = 0;
    cyc = 0;
    while ((acc < 1000 || eq.size() > 0) && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      sw_or[k] = ($urandom_range(0, 3) != 0);
      sw_iv[k] = (acc < 1000) && ($urandom_range(0, 4) != 0);
      sw_a[k]  = pick(w);
      sw_b[k]  = pick(w);
      sw_s[k]  = 1'($urandom_range(0, 1));
      sw_t[k]  = 4'($urandom);
      #1;
      if (eq.size() == 0) begin
        check($sformatf("w%0d_no_spurious", w), 64'(sw_ov[k]), 64'd0);
      end else if (sw_ov[k]) begin
        check($sformatf("w%0d_p", w), sw_p[k], eq[0]);
        check($sformatf("w%0d_tag", w), 64'(sw_ot[k]), 64'(tq[0]));
        if (sw_or[k]) begin
          void'(eq.pop_front());
          void'(tq.pop_front());
        end
      end
      if (sw_iv[k] && sw_ir[k]) begin
        eq.push_back(ref_prod(w, sw_a[k], sw_b[k], sw_s[k]));
        tq.push_back(sw_t[k]);
        acc++;
      end
    end
    sw_iv[k] = 1'b0;
    check($sformatf("w%0d_accepted", w), 64'(acc), 64'd1000);
    check($sformatf("w%0d_drained", w), 64'(eq.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; t8 = '0;
    for (int k = 0; k < 3; k++) begin
      sw_iv[k] = 1'b0; sw_or[k] = 1'b1; sw_a[k] = '0; sw_b[k] = '0; sw_s[k] = 1'b0; sw_t[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 64'(ov8), 64'd0);
    check("reset_out_p", 64'(p8), 64'd0);
    check("reset_out_tag", 64'(ot8), 64'd0);
    check("reset_in_ready", 64'(ir8), 64'd1);
    for (int k = 0; k < 3; k++) check("reset_sweep_valid", 64'(sw_ov[k]), 64'd0);

    single8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_255x255");
    single8(8'h00, 8'hAD, 1'b0, 16'h0000, "u_0x173");
    single8(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_x_min");
    single8(8'h80, 8'h7F, 1'b1, 16'hC080, "s_min_x_max");
    single8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_m1_x_1");

    // Backpressure: five tagged transactions, output stalled for 4 cycles after first result.
    begin
      int sent, got, stall, cyc;
      bit seen;
      logic [15:0] hp;
      logic [3:0]  ht;
      logic [3:0]  rx [$];
      sent = 0; got = 0; stall = 4; cyc = 0; seen = 1'b0; hp = '0; ht = '0;
      while (got < 5 && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (seen && stall > 0) begin
          or8 = 1'b0;
          stall--;
        end else begin
          or8 = 1'b1;
        end
        if (sent < 5) begin
          iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
          s8 = 1'($urandom_range(0, 1)); t8 = 4'(sent + 1);
        end else begin
          iv8 = 1'b0;
        end
        #1;
        if (!or8 && ov8) begin
          check("bp_in_ready_low", 64'(ir8), 64'd0);
          if (stall == 3) begin
            hp = p8;
            ht = ot8;
          end else begin
            check("bp_hold_p", 64'(p8), 64'(hp));
            check("bp_hold_tag", 64'(ot8), 64'(ht));
          end
        end
        if (ov8 && or8) begin
          rx.push_back(ot8);
          got++;
        end
        if (ov8) seen = 1'b1;
        if (iv8 && ir8) sent++;
      end
      iv8 = 1'b0;
      or8 = 1'b1;
      check("bp_result_count", 64'(got), 64'd5);
      for (int i = 0; i < rx.size(); i++) check("bp_tag_order", 64'(rx[i]), 64'(i + 1));
    end

    // Full throughput, mode toggling every cycle.
    repeat (4) @(negedge clk);
    for (int k = 0; k < 100 + LATENCY; k++) begin
      @(negedge clk);
      or8 = 1'b1;
      if (k < 100) begin
        iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); s8 = k[0]; t8 = 4'($urandom);
      end else begin
        iv8 = 1'b0;
      end
      #1;
      if (k < 100) check("thru_in_ready", 64'(ir8), 64'd1);
      if (k >= LATENCY) check("thru_out_valid", 64'(ov8), 64'd1);
    end

    // Reset with three transactions in flight.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      iv8 = 1'b1; or8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'b0; t8 = 4'(k + 10);
    end
    @(negedge clk);
    iv8 = 1'b0; or8 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(ov8), 64'd0);
    check("midrst_out_p", 64'(p8), 64'd0);
    check("midrst_in_ready", 64'(ir8), 64'd1);
    or8 = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1;
      check("midrst_quiet", 64'(ov8), 64'd0);
    end

    // WIDTH=4 most-negative squared.
    @(negedge clk);
    sw_a[0] = 32'h8; sw_b[0] = 32'h8; sw_s[0] = 1'b1; sw_t[0] = 4'd9; sw_iv[0] = 1'b1; sw_or[0] = 1'b1;
    for (int k = 1; k <= LATENCY; k++) begin
      @(negedge clk);
      sw_iv[0] = 1'b0;
      #1;
      if (k == LATENCY) begin
        check("w4_min_x_min_valid", 64'(sw_ov[0]), 64'd1);
        check("w4_min_x_min", sw_p[0], 64'h40);
        check("w4_min_x_min_tag", 64'(sw_ot[0]), 64'd9);
      end
    end
    repeat (2) @(negedge clk);

    fork
      sweep(0, 4);
      sweep(1, 16);
      sweep(2, 32);
    join

    repeat (4) @(negedge clk);
    check("w8_drained", 64'(q8_p.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_tree_multiplier.md
Name: pipelined_tree_multiplier

Overview:
Parametrised, pipelined Wallace-style tree multiplier for WIDTH x WIDTH operands, producing an exact 2*WIDTH-bit product. It adds a per-transaction signed/unsigned mode, valid/ready handshakes with backpressure, and a sideband tag that travels with each operand pair. It is the general datapath multiplier for the arithmetic blocks in the multipliers collection and replaces fixed 4x4 combinational multipliers.

Parameters:
WIDTH, 8, operand width in bits; legal range 4..32.
TAG_W, 4, width of the sideband tag carried alongside each transaction; legal range 1..16.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair presented.
in_ready  output  1  block accepts the operand pair this cycle.
in_a  input  WIDTH  multiplicand.
in_b  input  WIDTH  multiplier.
in_signed  input  1  1 = two's-complement operands; 0 = unsigned operands.
in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
out_valid  output  1  result presented.
out_ready  input  1  downstream accepts the result.
out_p  output  2*WIDTH  exact product.
out_tag  output  TAG_W  tag of this result.

Behaviour:
- Reset: synchronous, active-high. Clears all stage valid bits, and drives out_valid=0, out_p=0, out_tag=0. in_ready=1 in the first cycle after reset is released. Reset taken mid-operation discards every in-flight transaction and produces no output for them.
- Pipeline: three registered stages, LATENCY=3.
  - S1: partial-product generation, WIDTH rows of WIDTH+1 bits each. Signed mode uses Baugh-Wooley inversion of the MSB row and column, plus the correction constant.
  - S2: 3:2 carry-save reduction tree down to two 2*WIDTH-bit vectors (sum and carry).
  - S3: final carry-propagate add. The S3 register drives out_p, out_tag and out_valid.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv.
  - All stage registers, including valid bits, load only when adv=1. Otherwise every stage holds its value.
  - Bubbles are not squeezed out during a stall.
- Acceptance: a transaction is accepted iff in_valid && in_ready. The result appears on out_p exactly 3 cycles later when no stall occurs. Each stalled cycle adds one cycle of latency.
- Output rules:
  - out_p and out_tag hold stable while out_valid && !out_ready.
  - A result is consumed iff out_valid && out_ready.
  - Consume and accept in the same cycle is legal and sustains one result per cycle.
- Invalid cycles: when in_valid=0 while in_ready=1, a bubble enters the pipeline. Data registers may load junk, but the associated valid bit is 0.
- Arithmetic:
  - Unsigned mode: out_p = a*b, in range 0..(2^WIDTH-1)^2.
  - Signed mode: out_p is the two's-complement product, sign-correct over 2*WIDTH bits.
  - The most-negative x most-negative case (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) must not overflow.
  - Results are never truncated or saturated.
- Mode capture: in_signed is captured per transaction at S1. Mixed-mode back-to-back transactions are legal.
- X-safety: out_valid is never X after reset. Data bits are don't-care whenever out_valid=0.

Decomposition:
- Shared package mult_pkg:
  - constant LATENCY=3;
  - function for the Baugh-Wooley correction constant as a function of WIDTH;
  - typedef for the tree stage-count calculation (number of 3:2 levels needed for a given WIDTH).
- One sub-module: csa_3to2, a WIDTH-parametrised carry-save adder. It is instantiated repeatedly in the S2 reduction tree, via a generate loop over tree levels.

Test Plan:
- Unsigned corners, WIDTH=8, out_ready=1.
  - a=255,b=255,signed=0 -> out_p=0xFE01 exactly 3 cycles after accept.
  - a=0,b=173 -> out_p=0x0000.
- Signed corners, WIDTH=8.
  - a=0x80,b=0x80,signed=1 -> out_p=0x4000.
  - a=0x80,b=0x7F -> out_p=0xC080.
  - a=0xFF,b=0x01 -> out_p=0xFFFF.
- Backpressure:
  - Stream 5 transactions with tags 1..5.
  - Hold out_ready=0 for 4 cycles starting after the first out_valid.
  - Required: in_ready=0 during the stall and out_p/out_tag stable.
  - All 5 results arrive in order, tags 1..5, none lost or duplicated.
- Full throughput with mixed modes:
  - 100 back-to-back random operand pairs, in_signed toggling every cycle, out_ready=1.
  - Required: one result per cycle after a 3-cycle fill, each matching the reference model.
- Reset mid-operation:
  - Accept 3 transactions, then assert rst for 1 cycle.
  - Required: out_valid=0 and out_p=0 the cycle after reset; none of the 3 results ever appears.
  - in_ready=1 the following cycle.
- Parametric sweep: WIDTH=4, 16, 32, each with 1000 random signed and unsigned pairs and random out_ready.
  - Required: zero mismatches against the behavioural product.
  - Also check WIDTH=4 a=0x8,b=0x8,signed=1 -> out_p=0x40.
